// File: rtl/dff_bank_pkg.sv
// Shared types and helpers for the arbitrated flop bank.
package dff_bank_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width of an index over n items; never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int RW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [RW-1:0]   rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [RW-1:0]   idx,
  output logic            any
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int off = 0; off < NREQ; off++) begin
      cand = (int'(rr_ptr) + off) % NREQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = RW'(cand);
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin shared access to a flop bank, with a clearing sweep after every reset.
module dff_bank_arbiter
  import dff_bank_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = clog2_min1(DEPTH),
  localparam int RW    = clog2_min1(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  rvalid,
  output logic [RW-1:0]         rid,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output state_e                dbg_state
);

  // Handshake: a requester holds req/we/addr/wdata until it sees gnt; a gnt
  // cycle means the access happens on that rising edge, and rvalid/rid/rdata
  // answer it in the following cycle. There is no back-pressure on responses.

  state_e               state;
  logic [AW-1:0]        init_ptr;
  logic [RW-1:0]        rr_ptr;
  logic [WIDTH-1:0]     bank [DEPTH];

  logic [NREQ-1:0]      arb_gnt;
  logic [RW-1:0]        win;
  logic                 arb_any;
  logic                 grant;
  logic                 win_we;
  logic [AW-1:0]        win_addr;
  logic [WIDTH-1:0]     win_wdata;
  logic                 in_range;

  rr_arbiter #(
    .NREQ (NREQ),
    .RW   (RW)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .idx    (win),
    .any    (arb_any)
  );

  assign grant     = (state == RUN) && arb_any;
  assign gnt       = (state == RUN) ? arb_gnt : '0;
  assign win_we    = we[win];
  assign win_addr  = addr[win*AW +: AW];
  assign win_wdata = wdata[win*WIDTH +: WIDTH];
  assign in_range  = int'(win_addr) < DEPTH;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_ptr <= '0;
      rr_ptr   <= '0;
      rvalid   <= 1'b0;
      rid      <= '0;
      rdata    <= '0;
      busy     <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          rvalid <= 1'b0;
          if (init_ptr == AW'(DEPTH - 1)) begin
            state <= RUN;
            busy  <= 1'b0;
          end else begin
            init_ptr <= init_ptr + 1'b1;
          end
        end
        RUN: begin
          rvalid <= grant;
          if (grant) begin
            rid    <= win;
            rdata  <= win_we ? win_wdata : (in_range ? bank[win_addr] : '0);
            rr_ptr <= (win == RW'(NREQ - 1)) ? '0 : win + 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Storage has no reset; the INIT sweep is what defines its contents.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      bank[init_ptr] <= '0;
    end else if (grant && win_we && in_range) begin
      bank[win_addr] <= win_wdata;
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench: init sweep, vector table of arbitration/access cycles, reset abort, out-of-range.
module tb_dff_bank_arbiter;
  import dff_bank_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (DEPTH 8) ----------------
  logic [3:0]  req = '0, we = '0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic        rvalid, busy;
  logic [1:0]  rid;
  logic [7:0]  rdata;
  state_e      dbg_state;

  dff_bank_arbiter #(.NREQ(4), .DEPTH(8), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rid(rid), .rdata(rdata), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT (DEPTH 6, out-of-range cases) ----------------
  logic [3:0]  req6 = '0, we6 = '0;
  logic [11:0] addr6 = '0;
  logic [31:0] wdata6 = '0;
  logic [3:0]  gnt6;
  logic        rvalid6, busy6;
  logic [1:0]  rid6;
  logic [7:0]  rdata6;
  state_e      dbg_state6;

  dff_bank_arbiter #(.NREQ(4), .DEPTH(6), .WIDTH(8)) dut6 (
    .clk(clk), .rst(rst), .req(req6), .we(we6), .addr(addr6), .wdata(wdata6),
    .gnt(gnt6), .rvalid(rvalid6), .rid(rid6), .rdata(rdata6), .busy(busy6),
    .dbg_state(dbg_state6)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_gnt;
    logic        exp_rvalid;
    logic [1:0]  exp_rid;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] w,
                              input logic [2:0] a0, input logic [2:0] a1,
                              input logic [2:0] a2, input logic [2:0] a3,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3,
                              input logic [3:0] g, input logic rv,
                              input logic [1:0] id, input logic [7:0] rd);
    vec_t v;
    v.req = r; v.we = w;
    v.addr = {a3, a2, a1, a0};
    v.wdata = {d3, d2, d1, d0};
    v.exp_gnt = g; v.exp_rvalid = rv; v.exp_rid = id; v.exp_rdata = rd;
    return v;
  endfunction

  // Drive one cycle of inputs, check the grant, then check the response after the edge.
  task automatic apply(input vec_t v, input int n);
    req = v.req; we = v.we; addr = v.addr; wdata = v.wdata;
    #1;
    chk($sformatf("v%0d_gnt", n), 32'(gnt), 32'(v.exp_gnt));
    tick();
    chk($sformatf("v%0d_rvalid", n), 32'(rvalid), 32'(v.exp_rvalid));
    chk($sformatf("v%0d_rid", n), 32'(rid), 32'(v.exp_rid));
    chk($sformatf("v%0d_rdata", n), 32'(rdata), 32'(v.exp_rdata));
  endtask

  // Single access by requester 0 of the DEPTH-6 instance.
  task automatic do6(input string nm, input logic w, input logic [2:0] a,
                     input logic [7:0] d, input logic [7:0] exp);
    req6 = 4'b0001; we6 = {3'b000, w}; addr6 = {9'd0, a}; wdata6 = {24'd0, d};
    #1;
    chk({nm, "_gnt"}, 32'(gnt6), 32'h1);
    tick();
    req6 = '0;
    chk({nm, "_rvalid"}, 32'(rvalid6), 32'h1);
    chk({nm, "_rid"}, 32'(rid6), 32'h0);
    chk({nm, "_rdata"}, 32'(rdata6), 32'(exp));
  endtask

  initial begin
    // rr_ptr is 1 when the table starts (set by the sweep before it).
    tbl[0]  = mk(4'b0001, 4'b0001, 3, 0, 0, 0, 8'hA5, 0, 0, 0, 4'b0001, 1, 0, 8'hA5);
    tbl[1]  = mk(4'b0001, 4'b0000, 3, 0, 0, 0, 0, 0, 0, 0,     4'b0001, 1, 0, 8'hA5);
    tbl[2]  = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0,     4'b0000, 0, 0, 8'hA5);
    tbl[3]  = mk(4'b1000, 4'b0000, 0, 0, 0, 5, 0, 0, 0, 0,     4'b1000, 1, 3, 8'h00);
    tbl[4]  = mk(4'b1111, 4'b1111, 0, 1, 2, 4, 8'h10, 8'h11, 8'h12, 8'h13, 4'b0001, 1, 0, 8'h10);
    tbl[5]  = mk(4'b1111, 4'b1111, 0, 1, 2, 4, 8'h10, 8'h11, 8'h12, 8'h13, 4'b0010, 1, 1, 8'h11);
    tbl[6]  = mk(4'b1111, 4'b1111, 0, 1, 2, 4, 8'h10, 8'h11, 8'h12, 8'h13, 4'b0100, 1, 2, 8'h12);
    tbl[7]  = mk(4'b1111, 4'b1111, 0, 1, 2, 4, 8'h10, 8'h11, 8'h12, 8'h13, 4'b1000, 1, 3, 8'h13);
    tbl[8]  = mk(4'b1111, 4'b1111, 0, 1, 2, 4, 8'h10, 8'h11, 8'h12, 8'h13, 4'b0001, 1, 0, 8'h10);
    tbl[9]  = mk(4'b0100, 4'b0000, 0, 0, 2, 0, 0, 0, 0, 0,     4'b0100, 1, 2, 8'h12);
    tbl[10] = mk(4'b1010, 4'b0000, 0, 3, 0, 4, 0, 0, 0, 0,     4'b1000, 1, 3, 8'h13);
    tbl[11] = mk(4'b0010, 4'b0000, 0, 3, 0, 0, 0, 0, 0, 0,     4'b0010, 1, 1, 8'hA5);
    tbl[12] = mk(4'b0001, 4'b0001, 6, 0, 0, 0, 8'h5A, 0, 0, 0, 4'b0001, 1, 0, 8'h5A);
    tbl[13] = mk(4'b0001, 4'b0000, 6, 0, 0, 0, 0, 0, 0, 0,     4'b0001, 1, 0, 8'h5A);
    tbl[14] = mk(4'b0011, 4'b0001, 6, 6, 0, 0, 8'hC3, 0, 0, 0, 4'b0010, 1, 1, 8'h5A);
    tbl[15] = mk(4'b0001, 4'b0001, 6, 0, 0, 0, 8'hC3, 0, 0, 0, 4'b0001, 1, 0, 8'hC3);
    tbl[16] = mk(4'b0010, 4'b0000, 0, 6, 0, 0, 0, 0, 0, 0,     4'b0010, 1, 1, 8'hC3);
    tbl[17] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0,     4'b0000, 0, 1, 8'hC3);

    // ---- reset values, with req1/req2 held through INIT ----
    req = 4'b0110; we = '0; addr = {3'd0, 3'd1, 3'd0, 3'd0};
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rid", 32'(rid), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_state", 32'(dbg_state), 32'(INIT));
    rst = 1'b0;
    #1;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("init_c%0d_busy", c), 32'(busy), 32'h1);
      chk($sformatf("init_c%0d_gnt", c), 32'(gnt), 32'h0);
      chk($sformatf("init6_c%0d_busy", c), 32'(busy6), (c < 6) ? 32'h1 : 32'h0);
      tick();
    end
    chk("c8_busy", 32'(busy), 32'h0);
    chk("c8_state", 32'(dbg_state), 32'(RUN));
    chk("c8_gnt", 32'(gnt), 32'b0010);
    tick();
    chk("c9_rvalid", 32'(rvalid), 32'h1);
    chk("c9_rid", 32'(rid), 32'h1);
    chk("c9_rdata", 32'(rdata), 32'h0);
    req = 4'b0100;
    #1;
    chk("c9_gnt", 32'(gnt), 32'b0100);
    tick();
    req = '0;
    chk("c10_rvalid", 32'(rvalid), 32'h1);
    chk("c10_rid", 32'(rid), 32'h2);
    chk("c10_rdata", 32'(rdata), 32'h0);
    tick();
    chk("c11_rvalid", 32'(rvalid), 32'h0);

    // ---- read every address: all cleared by the sweep ----
    for (int a = 0; a < 8; a++) begin
      req = 4'b0001; we = '0; addr = {9'd0, 3'(a)};
      #1;
      chk($sformatf("sweep_a%0d_gnt", a), 32'(gnt), 32'h1);
      exp_q.push_back(8'h00);
      tick();
      chk($sformatf("sweep_a%0d_rvalid", a), 32'(rvalid), 32'h1);
      if (rvalid && exp_q.size() > 0)
        chk($sformatf("sweep_a%0d_rdata", a), 32'(rdata), 32'(exp_q.pop_front()));
    end
    req = '0;
    chk("sweep_q_empty", 32'(exp_q.size()), 32'h0);
    tick();

    // ---- table ----
    for (int i = 0; i < 18; i++) apply(tbl[i], i);

    // ---- reset pulse during a write grant to addr 2 ----
    req = 4'b0001; we = 4'b0001; addr = {9'd0, 3'd2}; wdata = {24'd0, 8'h77};
    #1;
    chk("abort_gnt_before", 32'(gnt), 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_gnt", 32'(gnt), 32'h0);
    chk("abort_rvalid", 32'(rvalid), 32'h0);
    chk("abort_rid", 32'(rid), 32'h0);
    chk("abort_rdata", 32'(rdata), 32'h0);
    chk("abort_busy", 32'(busy), 32'h1);
    chk("abort_state", 32'(dbg_state), 32'(INIT));
    rst = 1'b0;
    req = '0; we = '0;
    #1;
    chk("reinit_c0_busy", 32'(busy), 32'h1);
    tick();
    chk("abort_no_rvalid", 32'(rvalid), 32'h0);
    for (int c = 1; c < 8; c++) begin
      chk($sformatf("reinit_c%0d_busy", c), 32'(busy), 32'h1);
      tick();
    end
    chk("reinit_c8_busy", 32'(busy), 32'h0);
    req = 4'b0001; we = '0; addr = {9'd0, 3'd2};
    #1;
    chk("reinit_rd2_gnt", 32'(gnt), 32'h1);
    tick();
    req = '0;
    chk("reinit_rd2_rvalid", 32'(rvalid), 32'h1);
    chk("reinit_rd2_rdata", 32'(rdata), 32'h0);

    // ---- out-of-range on the DEPTH-6 instance ----
    do6("d6_wr5", 1'b1, 3'd5, 8'h33, 8'h33);
    do6("d6_wr7", 1'b1, 3'd7, 8'hFF, 8'hFF);
    do6("d6_rd7", 1'b0, 3'd7, 8'h00, 8'h00);
    do6("d6_rd1", 1'b0, 3'd1, 8'h00, 8'h00);
    do6("d6_rd5", 1'b0, 3'd5, 8'h00, 8'h33);
    tick();
    chk("d6_idle_rvalid", 32'(rvalid6), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
